// File: rtl/cdc_pkg.sv
// Shared types and helpers for the reset-crossing blocks.
// Holds the request-generator state encoding and a counter-width helper.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD        = 2'd1,
    WAIT_ASSERT = 2'd2,
    WAIT_REL    = 2'd3
  } rst_req_state_t;

  // Bits needed to hold the value max_val without wrapping (at least 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-stage single-bit synchronizer for a level crossing into clk.
// The reset value is a parameter so the chain can come up at a known level.
module cdc_bit_sync
  import cdc_pkg::*;
#(
  parameter int   STAGES    = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic async_clr,
  input  logic i_d,
  output logic o_q
);

  (* async_reg = "true" *) logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge async_clr) begin
    if (async_clr) r_sync <= {STAGES{RESET_VAL}};
    else           r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_rst_req_gen.sv
// Reset-crossing initiator: turns a request pulse into a held reset level
// toward a remote domain and waits for its synchronized status to confirm
// assertion and release.
// Optional feature macro: CDC_RST_REQ_GEN_TIMEOUT_EN (ack wait timeout).
module cdc_rst_req_gen
  import cdc_pkg::*;
#(
  parameter int SYNC_FF         = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter bit RST_ACTIVE_HIGH = 1'b0,
  parameter bit ACK_ACTIVE_HIGH = 1'b0,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic clk,
  input  logic async_clr,
  input  logic rst_req,
  input  logic rst_ack_in,
  output logic rst_out,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  localparam int              CNT_W     = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(HOLD_CYCLES);
  localparam logic             RST_ON    = RST_ACTIVE_HIGH ? 1'b1 : 1'b0;
  localparam logic             ACK_ON    = ACK_ACTIVE_HIGH ? 1'b1 : 1'b0;

  if (SYNC_FF < 2 || SYNC_FF > 8) begin : g_bad_sync_ff
    $error("cdc_rst_req_gen: SYNC_FF must be in 2..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("cdc_rst_req_gen: HOLD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cdc_rst_req_gen: TIMEOUT_CYCLES must be >= 1");
  end

  rst_req_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_rst_out;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout_err;

  rst_req_state_t   w_next_state;
  logic             w_cnt_clr;
  logic             w_pend_next;
  logic             w_done_next;
  logic             w_timeout;
  logic             w_tout_hit;
  logic             w_ack_sync;
  logic             w_ack_a;

  // The chain resets to the asserted level, matching a remote that is held
  // in reset while this block is in reset.
  cdc_bit_sync #(
    .STAGES    (SYNC_FF),
    .RESET_VAL (ACK_ON)
  ) u_ack_sync (
    .clk       (clk),
    .async_clr (async_clr),
    .i_d       (rst_ack_in),
    .o_q       (w_ack_sync)
  );

  assign w_ack_a = (w_ack_sync == ACK_ON);

`ifdef CDC_RST_REQ_GEN_TIMEOUT_EN
  localparam int              TOUT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TOUT_W-1:0] r_tcnt;

  // Count cycles spent waiting for the ack; restart on every state change.
  always_ff @(posedge clk or posedge async_clr) begin
    if (async_clr) begin
      r_tcnt <= '0;
    end else if (w_next_state != r_state) begin
      r_tcnt <= '0;
    end else if ((r_state == WAIT_ASSERT || r_state == WAIT_REL) && r_tcnt != TOUT_LAST) begin
      r_tcnt <= r_tcnt + TOUT_W'(1);
    end
  end

  assign w_tout_hit = (r_tcnt == TOUT_LAST);
`else
  assign w_tout_hit = 1'b0;
`endif

  // Next-state decision; any accepted request restarts the hold from zero.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_pend_next  = r_pending;
    w_done_next  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_req) begin
          w_next_state = HOLD;
          w_cnt_clr    = 1'b1;
        end
      end
      HOLD: begin
        if (rst_req) begin
          w_cnt_clr = 1'b1;
        end else if (r_cnt == HOLD_LAST) begin
          w_next_state = WAIT_ASSERT;
        end
      end
      WAIT_ASSERT: begin
        if (rst_req) begin
          w_next_state = HOLD;
          w_cnt_clr    = 1'b1;
        end else if (w_ack_a) begin
          w_next_state = WAIT_REL;
        end else if (w_tout_hit) begin
          w_next_state = WAIT_REL;
          w_timeout    = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!w_ack_a) begin
          w_pend_next = 1'b0;
          if (r_pending || rst_req) begin
            w_next_state = HOLD;
            w_cnt_clr    = 1'b1;
          end else begin
            w_next_state = IDLE;
            w_done_next  = ~r_timeout_err;
          end
        end else if (w_tout_hit) begin
          w_next_state = IDLE;
          w_pend_next  = 1'b0;
          w_timeout    = 1'b1;
        end else if (rst_req) begin
          w_pend_next = 1'b1;
        end
      end
      default: begin
        w_next_state = HOLD;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  // State, hold counter and outputs, all registered from the next state.
  always_ff @(posedge clk or posedge async_clr) begin
    if (async_clr) begin
      r_state       <= HOLD;
      r_cnt         <= '0;
      r_pending     <= 1'b0;
      r_rst_out     <= RST_ON;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_pend_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state == HOLD && r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_rst_out <= (w_next_state == HOLD || w_next_state == WAIT_ASSERT) ? RST_ON : ~RST_ON;
      r_busy    <= (w_next_state != IDLE);
      r_done    <= w_done_next;
      if (w_cnt_clr) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign rst_out     = r_rst_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule
